osd_tracepacket: RTL and testbench

Consumer end of the trace sampling path: pops entries (sample or overflow marker) from the trace FIFO and serializes each into one debug event packet on the 16-bit debug interconnect output. Sits between the trace FIFO and the debug module's packet output port; it owns the packet header, payload ordering and overflow-event encoding.

---
 rtl/osd_tracepacket.sv | 154 +++++++++++++++
 tb/tb_osd_tracepacket.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_tracepacket.sv
// osd_tracepacket
// Pops one entry (trace sample or overflow marker) from the trace FIFO and
// serializes it into a debug event packet on the 16-bit debug interconnect.
//
// Packet: DEST, id, flags {2'b10, subtype, 10'b0}, then payload.
//   subtype 0 (sample)   : WIDTH/16 payload words, least significant first
//   subtype 1 (overflow) : one word {6'b0, dropped-sample count[9:0]}
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   id                  own module address (header word 1)
//   trace_data          FIFO head entry
//   trace_overflow      head entry is an overflow marker
//   trace_valid/ready   FIFO pop handshake
//   debug_out_data      packet word
//   debug_out_last      final word of the packet
//   debug_out_valid/ready  output word handshake
module osd_tracepacket #(
    parameter int          WIDTH = 16,
    parameter logic [15:0] DEST  = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id,
    input  logic [WIDTH-1:0] trace_data,
    input  logic             trace_overflow,
    input  logic             trace_valid,
    output logic             trace_ready,
    output logic [15:0]      debug_out_data,
    output logic             debug_out_last,
    output logic             debug_out_valid,
    input  logic             debug_out_ready
);

    localparam int NW = WIDTH / 16;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR_DEST,
        HDR_SRC,
        HDR_FLAGS,
        PAYLOAD
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] hold_data;
    logic             hold_ovf;
    logic             pop;

    function automatic logic [15:0] word_sel(input logic [WIDTH-1:0] h,
                                             input logic [CW-1:0]    idx);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < NW; i++) begin
            if (idx == CW'(i)) w = h[i*16 +: 16];
        end
        return w;
    endfunction

    function automatic logic [15:0] flags_word(input logic ovf);
        return {2'b10, (ovf ? 4'h1 : 4'h0), 10'b0};
    endfunction

    // Only IDLE accepts an entry, so a second pop cannot happen before the
    // current packet's last word has been accepted.
    assign trace_ready = (state == IDLE) && !rst;
    assign pop         = trace_valid && trace_ready;
    assign cnt_nxt     = cnt + CW'(1);

    // The entry is frozen here for the whole packet; the FIFO head is free
    // to change once it has been popped.
    always_ff @(posedge clk) begin
        if (pop) begin
            hold_data <= trace_data;
            hold_ovf  <= trace_overflow;
        end
    end

    // Outputs are registered and only move on an accepted word, which keeps
    // data/last/valid stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            debug_out_valid <= 1'b0;
            debug_out_last  <= 1'b0;
            debug_out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state           <= HDR_DEST;
                        cnt             <= '0;
                        debug_out_valid <= 1'b1;
                        debug_out_last  <= 1'b0;
                        debug_out_data  <= DEST;
                    end
                end
                HDR_DEST: begin
                    if (debug_out_ready) begin
                        state          <= HDR_SRC;
                        debug_out_data <= id;
                    end
                end
                HDR_SRC: begin
                    if (debug_out_ready) begin
                        state          <= HDR_FLAGS;
                        debug_out_data <= flags_word(hold_ovf);
                    end
                end
                HDR_FLAGS: begin
                    if (debug_out_ready) begin
                        state <= PAYLOAD;
                        cnt   <= '0;
                        if (hold_ovf) begin
                            debug_out_data <= {6'b0, hold_data[9:0]};
                            debug_out_last <= 1'b1;
                        end else begin
                            debug_out_data <= hold_data[15:0];
                            debug_out_last <= (NW == 1);
                        end
                    end
                end
                PAYLOAD: begin
                    if (debug_out_ready) begin
                        if (debug_out_last) begin
                            state           <= IDLE;
                            cnt             <= '0;
                            debug_out_valid <= 1'b0;
                            debug_out_last  <= 1'b0;
                            debug_out_data  <= '0;
                        end else begin
                            cnt            <= cnt_nxt;
                            debug_out_data <= word_sel(hold_data, cnt_nxt);
                            debug_out_last <= (cnt_nxt == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    cnt             <= '0;
                    debug_out_valid <= 1'b0;
                    debug_out_last  <= 1'b0;
                    debug_out_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osd_tracepacket.sv
// Testbench for osd_tracepacket: a FIFO model feeds entries, each issued
// entry pushes its expected packet words into a scoreboard queue, and a
// monitor pops and compares every accepted output word. A second instance
// with WIDTH=16 is checked directly.
module tb_osd_tracepacket;

    localparam int          W   = 32;
    localparam logic [15:0] DST = 16'h0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0]  id             = 16'h0005;
    logic [W-1:0] trace_data     = '0;
    logic         trace_overflow = 1'b0;
    logic         trace_valid    = 1'b0;
    logic         trace_ready;
    logic [15:0]  dout;
    logic         dlast;
    logic         dvalid;
    logic         dready         = 1'b1;

    osd_tracepacket #(.WIDTH(W), .DEST(DST)) dut (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .trace_data      (trace_data),
        .trace_overflow  (trace_overflow),
        .trace_valid     (trace_valid),
        .trace_ready     (trace_ready),
        .debug_out_data  (dout),
        .debug_out_last  (dlast),
        .debug_out_valid (dvalid),
        .debug_out_ready (dready)
    );

    logic [15:0] t16_data  = 16'h0000;
    logic        t16_valid = 1'b0;
    logic        t16_ready;
    logic [15:0] d16;
    logic        l16;
    logic        v16;

    osd_tracepacket #(.WIDTH(16), .DEST(DST)) dut16 (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .trace_data      (t16_data),
        .trace_overflow  (1'b0),
        .trace_valid     (t16_valid),
        .trace_ready     (t16_ready),
        .debug_out_data  (d16),
        .debug_out_last  (l16),
        .debug_out_valid (v16),
        .debug_out_ready (1'b1)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         ovf;
    } entry_t;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } word_t;

    entry_t fq[$];
    word_t  exp_q[$];

    int checks    = 0;
    int failures  = 0;
    int pops      = 0;
    int exp_pops  = 0;
    logic fire_n  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Queue an entry into the FIFO model and its packet into the scoreboard.
    task automatic send(input logic [W-1:0] d, input logic ovf);
        entry_t e;
        word_t  w;
        e.data = d;
        e.ovf  = ovf;
        fq.push_back(e);
        exp_pops++;
        w.last = 1'b0;
        w.data = DST;   exp_q.push_back(w);
        w.data = id;    exp_q.push_back(w);
        w.data = ovf ? 16'h8400 : 16'h8000;
        exp_q.push_back(w);
        if (ovf) begin
            w.data = {6'b0, d[9:0]};
            w.last = 1'b1;
            exp_q.push_back(w);
        end else begin
            for (int i = 0; i < W/16; i++) begin
                w.data = d[i*16 +: 16];
                w.last = (i == W/16 - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic wait_drain(input int budget, input logic stall);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && fq.size() == 0 && !dvalid) && n < budget) begin
            if (stall) dready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        dready = 1'b1;
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_words_left required=0", exp_q.size());
            exp_q.delete();
            fq.delete();
        end
    endtask

    // FIFO model: pop the head after a handshake, present the next head.
    always @(posedge clk) begin
        #2;
        if (fire_n && fq.size() > 0) void'(fq.pop_front());
        if (fq.size() > 0) begin
            trace_valid    = 1'b1;
            trace_data     = fq[0].data;
            trace_overflow = fq[0].ovf;
        end else begin
            trace_valid    = 1'b0;
            trace_data     = W'($urandom);
            trace_overflow = 1'b0;
        end
    end

    // Monitor: samples on the falling edge, between driving and capture.
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b1;
    logic [15:0] pd = '0;
    always @(negedge clk) begin
        word_t e;
        if (!prst && pv && !pr) begin
            chk("stall_valid", 32'(dvalid), 32'd1);
            chk("stall_data",  32'(dout),   32'(pd));
            chk("stall_last",  32'(dlast),  32'(pl));
        end
        if (!prst && pv && pr && pl)  chk("idle_gap", 32'(dvalid), 32'd0);
        if (!prst && pv && pr && !pl) chk("no_gap",   32'(dvalid), 32'd1);
        if (!prst && fire_n) begin
            chk("pop_latency", 32'(dvalid), 32'd1);
            chk("pop_word0",   32'(dout),   32'(DST));
        end
        if (rst) chk("ready_in_rst", 32'(trace_ready), 32'd0);
        if (dvalid && dready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", dout);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", 32'(dout),  32'(e.data));
                chk("word_last", 32'(dlast), 32'(e.last));
            end
        end
        if (trace_valid && trace_ready) pops++;
        fire_n = trace_valid && trace_ready;
        pv   = dvalid;
        pr   = dready;
        pl   = dlast;
        pd   = dout;
        prst = rst;
    end

    // WIDTH=16 instance: one sample packet with output ready held high.
    logic [15:0] e16 [4];
    int n16 = 0;
    int p16 = 0;
    initial begin
        e16[0] = 16'h0001; e16[1] = 16'h0005; e16[2] = 16'h8000; e16[3] = 16'hABCD;
        wait (!rst);
        @(posedge clk); #1;
        t16_data  = 16'hABCD;
        t16_valid = 1'b1;
        repeat (12) begin
            if (t16_valid && t16_ready) p16++;
            @(posedge clk); #1;
            if (p16 > 0) begin
                t16_valid = 1'b0;
                t16_data  = 16'h1111;
            end
            if (v16) begin
                if (n16 < 4) begin
                    chk("w16_data", 32'(d16), 32'(e16[n16]));
                    chk("w16_last", 32'(l16), 32'(n16 == 3));
                end
                n16++;
            end
        end
        chk("w16_words", 32'(n16), 32'd4);
        chk("w16_pops",  32'(p16), 32'd1);
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(dvalid),      32'd0);
        chk("rst_last",  32'(dlast),       32'd0);
        chk("rst_data",  32'(dout),        32'd0);
        chk("rst_ready", 32'(trace_ready), 32'd0);
        rst = 1'b0;

        // No entries: output stays idle, FIFO side ready
        repeat (20) begin
            @(posedge clk); #1;
            chk("idle_valid", 32'(dvalid),      32'd0);
            chk("idle_ready", 32'(trace_ready), 32'd1);
        end

        // Two-word sample
        send(32'h1234_5678, 1'b0);
        wait_drain(50, 1'b0);

        // Saturated overflow count with upper bits set
        send(32'hFFFF_FFFF, 1'b1);
        wait_drain(50, 1'b0);

        // Back-to-back entries under random backpressure
        send(32'hCAFE_0001, 1'b0);
        send(32'h5A5A_5D23, 1'b1);
        send(32'h0BAD_F00D, 1'b0);
        wait_drain(400, 1'b1);

        // Reset while the flags word is on the output
        send(32'hDEAD_BEEF, 1'b0);
        n = 0;
        while (!(dvalid && dout == 16'h8000) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 30) begin
            checks++;
            failures++;
            $display("FAIL flags_timeout actual=%h required=8000", dout);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", 32'(dvalid), 32'd0);
        chk("abort_last",  32'(dlast),  32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(32'h0246_8ACE, 1'b0);
        wait_drain(50, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("pop_count", 32'(pops), 32'(exp_pops));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
